// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 codes (F3_B/H/W/BU/HU)
//   - FSM state encoding (lsu_state_t)
//   - error-cause encoding (lsu_err_t) and the accept-time legality check
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_FUNCT3,
      ERR_MISALIGN,
      ERR_RANGE
   } lsu_err_t;

   // Classifies a request at accept time. An unknown funct3 is reported first
   // because alignment has no meaning for it; range is checked last so that a
   // misaligned access to a legal word is reported as misaligned.
   function automatic lsu_err_t check_access(input logic        we,
                                             input logic [2:0]  funct3,
                                             input logic [31:0] addr,
                                             input int unsigned mem_words);
      logic f3_ok;
      if (we)
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);

      if (!f3_ok)
         return ERR_FUNCT3;
      if (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
         return ERR_MISALIGN;
      if ((funct3 == F3_W) && (addr[1:0] != 2'b00))
         return ERR_MISALIGN;
      if ({2'b00, addr[31:2]} >= mem_words)
         return ERR_RANGE;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   word       in  32  word currently read from data memory
//   byte_off   in   2  low address bits of the access
//   funct3     in   3  RV32I load/store funct3
//   wdata      in  32  store data (low byte/half used for SB/SH)
//   load_value out 32  selected lane, sign- or zero-extended
//   store_word out 32  memory word with the store lane merged in
// ---------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_value,
   output logic [31:0] store_word
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed byte/half out of the word, then extend it according
   // to the load flavour. Word loads pass straight through.
   always_comb begin
      case (byte_off)
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         2'd3:    sel_byte = word[31:24];
         default: sel_byte = word[7:0];
      endcase
      sel_half = byte_off[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_value = {24'd0, sel_byte};
         F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_value = {16'd0, sel_half};
         default: load_value = word;
      endcase
   end

   // Read-modify-write merge: the memory has no byte enables, so sub-word
   // stores overlay their lane onto the current word and write it back whole.
   always_comb begin
      store_word = word;
      case (funct3)
         F3_B: begin
            case (byte_off)
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               2'd3:    store_word[31:24] = wdata[7:0];
               default: store_word[7:0]   = wdata[7:0];
            endcase
         end
         F3_H: begin
            if (byte_off[1])
               store_word[31:16] = wdata[15:0];
            else
               store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the MEM pipeline stage to a word-wide data memory (combinational
// read, word-only synchronous write). Loads get lane extraction and
// extension; SB/SH become read-modify-write; bad accesses are answered with
// resp_err and never reach memory. One operation in flight at a time.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_we, req_funct3       store flag, RV32I funct3
//   req_addr, req_wdata      byte address, store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     load result / error flag, held until next accept
//   mem_we, mem_address      data-memory write enable, word-aligned address
//   mem_w_data, mem_r_data   data-memory write word / read word
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_address,
   output logic [31:0] mem_w_data,
   input  logic [31:0] mem_r_data
);

   lsu_state_t  state;
   lsu_err_t    req_cause;
   logic        mem_we_q;
   logic        lat_we;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_off;
   logic [31:0] lat_wdata;
   logic [31:0] load_value;
   logic [31:0] store_word;

   // Legality of the request as presented, evaluated in the accept cycle.
   always_comb begin
      req_cause = check_access(req_we, req_funct3, req_addr, MEM_WORDS);
   end

   lsu_align u_align (
      .word       (mem_r_data),
      .byte_off   (lat_off),
      .funct3     (lat_funct3),
      .wdata      (lat_wdata),
      .load_value (load_value),
      .store_word (store_word)
   );

   // The write enable is registered, but a reset raised during the write
   // cycle must still stop the memory from committing the pending word, so
   // reset masks it directly.
   assign mem_we = mem_we_q & ~rst;

   // Main FSM. SW raises the write enable straight from the accept so the
   // word is written during ACCESS; SB/SH first read the word in ACCESS,
   // register the merged word, and write it during WRITE. mem_address is
   // only updated on a legal accept, so it stays put through ACCESS/WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_address <= 32'd0;
         mem_w_data  <= 32'd0;
         lat_we      <= 1'b0;
         lat_funct3  <= 3'd0;
         lat_off     <= 2'd0;
         lat_wdata   <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         mem_we_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  lat_we     <= req_we;
                  lat_funct3 <= req_funct3;
                  lat_off    <= req_addr[1:0];
                  lat_wdata  <= req_wdata;
                  req_ready  <= 1'b0;
                  resp_rdata <= 32'd0;
                  if (req_cause != ERR_NONE) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     resp_err    <= 1'b0;
                     mem_address <= {req_addr[31:2], 2'b00};
                     state       <= ST_ACCESS;
                     if (req_we && (req_funct3 == F3_W)) begin
                        mem_we_q   <= 1'b1;
                        mem_w_data <= req_wdata;
                     end
                  end
               end
            end
            ST_ACCESS: begin
               if (!lat_we) begin
                  resp_rdata <= load_value;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else if (lat_funct3 == F3_W) begin
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  mem_we_q   <= 1'b1;
                  mem_w_data <= store_word;
                  state      <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a word-wide data-memory model.
// Expected responses are queued when a request is driven and compared when
// the unit pulses resp_valid.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_address;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;

   logic [31:0] mem [0:1023];
   int          we_count = 0;
   logic [31:0] last_we_addr = 32'd0;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_we      (mem_we),
      .mem_address (mem_address),
      .mem_w_data  (mem_w_data),
      .mem_r_data  (mem_r_data)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, word write on the clock edge.
   assign mem_r_data = mem[mem_address[11:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_address[11:2]] <= mem_w_data;
         we_count               <= we_count + 1;
         last_we_addr           <= mem_address;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Queues the expected response, presents the request and returns one
   // step after the accepting edge with req_valid dropped.
   task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat);
      exp_t e;
      int   n;
      e.tag   = tag;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      exp_q.push_back(e);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Waits (bounded) for the response of the oldest queued request and
   // compares latency, data, error flag and the single-cycle pulse.
   task automatic collectResponse();
      exp_t e;
      int   n;
      if (exp_q.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      n = 1;
      while (!resp_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({e.tag, "_valid"},   {31'd0, resp_valid}, 32'd1);
      checkOutput({e.tag, "_latency"}, 32'(n), 32'(e.lat));
      checkOutput({e.tag, "_rdata"},   resp_rdata, e.rdata);
      checkOutput({e.tag, "_err"},     {31'd0, resp_err}, {31'd0, e.err});
      @(posedge clk); #1;
      checkOutput({e.tag, "_pulse"},   {31'd0, resp_valid}, 32'd0);
      checkOutput({e.tag, "_hold"},    resp_rdata, e.rdata);
   endtask

   int we_before;

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready",   {31'd0, req_ready},  32'd1);
      checkOutput("rst_valid",   {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_rdata",   resp_rdata,          32'd0);
      checkOutput("rst_err",     {31'd0, resp_err},   32'd0);
      checkOutput("rst_mem_we",  {31'd0, mem_we},     32'd0);
      checkOutput("rst_address", mem_address,         32'd0);
      checkOutput("rst_wdata",   mem_w_data,          32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] word store");
      we_before = we_count;
      applyStimulus("sw_10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
      checkOutput("sw_10_we_access", {31'd0, mem_we}, 32'd1);
      checkOutput("sw_10_addr",      mem_address,     32'h10);
      checkOutput("sw_10_wdata",     mem_w_data,      32'hDEADBEEF);
      collectResponse();
      checkOutput("sw_10_we_count",  32'(we_count - we_before), 32'd1);
      checkOutput("sw_10_we_addr",   last_we_addr, 32'h10);
      checkOutput("sw_10_mem",       mem[4], 32'hDEADBEEF);

      $display("[TB] preload and lane loads");
      applyStimulus("sw_20", 1'b1, F3_W, 32'h20,  32'h80FF7F01, 32'd0, 1'b0, 2);
      collectResponse();
      applyStimulus("sw_30", 1'b1, F3_W, 32'h30,  32'h11223344, 32'd0, 1'b0, 2);
      collectResponse();
      applyStimulus("sw_40", 1'b1, F3_W, 32'h40,  32'hCAFEF00D, 32'd0, 1'b0, 2);
      collectResponse();
      applyStimulus("sw_ffc", 1'b1, F3_W, 32'hFFC, 32'h0BADF00D, 32'd0, 1'b0, 2);
      collectResponse();

      applyStimulus("lb_23",  1'b0, F3_B,  32'h23, 32'd0, 32'hFFFFFF80, 1'b0, 2);
      collectResponse();
      applyStimulus("lbu_23", 1'b0, F3_BU, 32'h23, 32'd0, 32'h00000080, 1'b0, 2);
      collectResponse();
      applyStimulus("lh_22",  1'b0, F3_H,  32'h22, 32'd0, 32'hFFFF80FF, 1'b0, 2);
      collectResponse();
      applyStimulus("lhu_20", 1'b0, F3_HU, 32'h20, 32'd0, 32'h00007F01, 1'b0, 2);
      collectResponse();
      applyStimulus("lb_21",  1'b0, F3_B,  32'h21, 32'd0, 32'h0000007F, 1'b0, 2);
      collectResponse();
      applyStimulus("lh_20",  1'b0, F3_H,  32'h20, 32'd0, 32'h00007F01, 1'b0, 2);
      collectResponse();
      applyStimulus("lw_ffc", 1'b0, F3_W,  32'hFFC, 32'd0, 32'h0BADF00D, 1'b0, 2);
      collectResponse();

      $display("[TB] sub-word stores");
      we_before = we_count;
      applyStimulus("sb_31", 1'b1, F3_B, 32'h31, 32'h123456AA, 32'd0, 1'b0, 3);
      collectResponse();
      checkOutput("sb_31_mem",      mem[12], 32'h1122AA44);
      checkOutput("sb_31_we_count", 32'(we_count - we_before), 32'd1);
      checkOutput("sb_31_we_addr",  last_we_addr, 32'h30);
      applyStimulus("sh_32", 1'b1, F3_H, 32'h32, 32'h9999BEEF, 32'd0, 1'b0, 3);
      collectResponse();
      checkOutput("sh_32_mem", mem[12], 32'hBEEFAA44);
      applyStimulus("lw_30", 1'b0, F3_W, 32'h30, 32'd0, 32'hBEEFAA44, 1'b0, 2);
      collectResponse();

      $display("[TB] error cases");
      applyStimulus("lw_20", 1'b0, F3_W, 32'h20, 32'd0, 32'h80FF7F01, 1'b0, 2);
      collectResponse();
      we_before = we_count;
      applyStimulus("err_lw_41",   1'b0, F3_W,   32'h41,   32'd0,        32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_sh_43",   1'b1, F3_H,   32'h43,   32'h0000FFFF, 32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_ld_f011", 1'b0, 3'b011, 32'h40,   32'd0,        32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_ld_f110", 1'b0, 3'b110, 32'h40,   32'd0,        32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_st_f011", 1'b1, 3'b011, 32'h40,   32'h11111111, 32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_st_bu",   1'b1, F3_BU,  32'h40,   32'h11111111, 32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_lw_1000", 1'b0, F3_W,   32'h1000, 32'd0,        32'd0, 1'b1, 1);
      collectResponse();
      applyStimulus("err_sw_1000", 1'b1, F3_W,   32'h1000, 32'h22222222, 32'd0, 1'b1, 1);
      collectResponse();
      checkOutput("err_no_writes", 32'(we_count - we_before), 32'd0);
      checkOutput("err_mem_40",    mem[16], 32'hCAFEF00D);

      $display("[TB] back-to-back requests");
      applyStimulus("b2b_a", 1'b0, F3_W, 32'h20, 32'd0, 32'h80FF7F01, 1'b0, 2);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = F3_BU;
      req_addr   = 32'h23;
      req_wdata  = 32'd0;
      checkOutput("b2b_busy_access", {31'd0, req_ready}, 32'd0);
      collectResponse();
      checkOutput("b2b_ready_after", {31'd0, req_ready}, 32'd1);
      applyStimulus("b2b_b", 1'b0, F3_BU, 32'h23, 32'd0, 32'h00000080, 1'b0, 2);
      collectResponse();

      $display("[TB] reset during read-modify-write");
      we_before = we_count;
      applyStimulus("rst_sb", 1'b1, F3_B, 32'h41, 32'h00000055, 32'd0, 1'b0, 3);
      @(posedge clk); #1;
      checkOutput("rst_sb_write_we",   {31'd0, mem_we}, 32'd1);
      checkOutput("rst_sb_write_addr", mem_address,     32'h40);
      checkOutput("rst_sb_write_word", mem_w_data,      32'hCAFE550D);
      rst = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("rst_sb_we_masked", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_sb_ready",    {31'd0, req_ready},  32'd1);
      checkOutput("rst_sb_mem_we",   {31'd0, mem_we},     32'd0);
      checkOutput("rst_sb_valid",    {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_sb_no_write", 32'(we_count - we_before), 32'd0);
      checkOutput("rst_sb_mem",      mem[16], 32'hCAFEF00D);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_sb_no_resp", {31'd0, resp_valid}, 32'd0);
      applyStimulus("rst_lw_40", 1'b0, F3_W, 32'h40, 32'd0, 32'hCAFEF00D, 1'b0, 2);
      collectResponse();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
